// File: rtl/isqrt_iter.sv
// rtl/isqrt_iter.sv - multi-cycle restoring integer square root, y = floor(sqrt(x)) for 32-bit x
// Define ISQRT_ITER_TWO_STEPS_EN to retire two result bits per clock (8 CALC cycles instead of 16).
module isqrt_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        x_rdy,
  output logic        y_vld,
  output logic [15:0] y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

`ifdef ISQRT_ITER_TWO_STEPS_EN
  localparam logic [3:0] LAST_CNT = 4'd7;
`else
  localparam logic [3:0] LAST_CNT = 4'd15;
`endif

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_op;
  logic [17:0] r_rem;
  logic [15:0] r_root;
  logic [3:0]  r_cnt;
  logic [15:0] r_y;
  logic        w_accept;
  logic [65:0] w_step1;
  logic [65:0] w_step;

  // One restoring step; result packed as {rem, root, op}.
  function automatic logic [65:0] sqrt_step(input logic [17:0] rem,
                                            input logic [15:0] root,
                                            input logic [31:0] op);
    logic [17:0] r2;
    logic [17:0] trial;
    logic [17:0] rem_n;
    logic [15:0] root_n;
    r2    = {rem[15:0], op[31:30]};
    trial = {root, 2'b01};
    if (r2 >= trial) begin
      rem_n  = r2 - trial;
      root_n = {root[14:0], 1'b1};
    end else begin
      rem_n  = r2;
      root_n = {root[14:0], 1'b0};
    end
    return {rem_n, root_n, op << 2};
  endfunction

  always_comb begin
    w_step1 = sqrt_step(r_rem, r_root, r_op);
`ifdef ISQRT_ITER_TWO_STEPS_EN
    w_step  = sqrt_step(w_step1[65:48], w_step1[47:32], w_step1[31:0]);
`else
    w_step  = w_step1;
`endif
  end

  assign x_rdy    = (r_state != S_CALC);
  assign y_vld    = (r_state == S_DONE);
  assign y        = r_y;
  assign w_accept = x_rdy && x_vld;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (x_vld) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == LAST_CNT) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = x_vld ? S_CALC : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= 32'd0;
      r_rem   <= 18'd0;
      r_root  <= 16'd0;
      r_cnt   <= 4'd0;
      r_y     <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op   <= x;
        r_rem  <= 18'd0;
        r_root <= 16'd0;
        r_cnt  <= 4'd0;
      end else if (r_state == S_CALC) begin
        r_rem  <= w_step[65:48];
        r_root <= w_step[47:32];
        r_op   <= w_step[31:0];
        r_cnt  <= r_cnt + 4'd1;
        // y is only updated on completion and holds between results.
        if (r_cnt == LAST_CNT) r_y <= w_step[47:32];
      end
    end
  end

endmodule

// File: tb/tb_isqrt_iter.sv
// tb/tb_isqrt_iter.sv - self-checking bench for isqrt_iter against an arithmetic floor(sqrt) model
module tb_isqrt_iter;

`ifdef ISQRT_ITER_TWO_STEPS_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 17;
`endif
  localparam int N_RAND = 2000;

  logic        clk;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic        x_rdy;
  logic        y_vld;
  logic [15:0] y;

  int n_tests = 0;
  int n_fail  = 0;

  isqrt_iter dut (
    .clk   (clk),
    .rst   (rst),
    .x_vld (x_vld),
    .x     (x),
    .x_rdy (x_rdy),
    .y_vld (y_vld),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint vv;
    longint r;
    vv = longint'({32'd0, v});
    r  = longint'($sqrt(real'(vv)));
    while (r * r > vv) r--;
    while ((r + 1) * (r + 1) <= vv) r++;
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present v in the current cycle (must be ready), then follow it to its DONE cycle.
  // Returns positioned in cycle k+LAT with x_vld low.
  task automatic run_op(input logic [31:0] v, input string tag);
    x_vld = 1'b1;
    x     = v;
    check({tag, "_rdy_at_accept"}, 32'(x_rdy), 32'd1);
    tick();
    x_vld = 1'b0;
    x     = $urandom;
    for (int i = 1; i < LAT; i++) begin
      check({tag, "_busy_rdy"}, 32'(x_rdy), 32'd0);
      check({tag, "_early_vld"}, 32'(y_vld), 32'd0);
      tick();
    end
    check({tag, "_vld"}, 32'(y_vld), 32'd1);
    check({tag, "_y"}, 32'(y), 32'(ref_sqrt(v)));
  endtask

  initial begin
    rst   = 1'b1;
    x_vld = 1'b0;
    x     = 32'd0;
    tick();
    check("reset_rdy", 32'(x_rdy), 32'd1);
    check("reset_vld", 32'(y_vld), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 30; i++) begin
      tick();
      check("idle_vld", 32'(y_vld), 32'd0);
      check("idle_y", 32'(y), 32'd0);
      check("idle_rdy", 32'(x_rdy), 32'd1);
    end

    run_op(32'd0, "x0");                tick(); tick();
    run_op(32'd1, "x1");                tick(); tick();
    run_op(32'd99, "x99");              tick(); tick();
    run_op(32'd1000000, "x1e6");
    check("x1e6_const", 32'(y), 32'd1000);
    tick(); tick();
    run_op(32'hFFFF_FFFF, "xmax");
    check("xmax_const", 32'(y), 32'd65535);
    tick();
    check("single_vld_pulse", 32'(y_vld), 32'd0);
    tick();

    // Busy rejection: a competing operand held during CALC must be ignored.
    x_vld = 1'b1;
    x     = 32'd144;
    tick();
    x = 32'd4;
    for (int i = 1; i < LAT; i++) begin
      check("busy_rdy", 32'(x_rdy), 32'd0);
      check("busy_vld", 32'(y_vld), 32'd0);
      tick();
    end
    x_vld = 1'b0;
    check("busy_done_vld", 32'(y_vld), 32'd1);
    check("busy_done_y", 32'(y), 32'd12);
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      check("busy_no_extra_vld", 32'(y_vld), 32'd0);
      check("busy_hold_y", 32'(y), 32'd12);
    end

    // Back-to-back: next operand accepted in the DONE cycle.
    run_op(32'd16, "b2b_16");
    check("b2b_16_const", 32'(y), 32'd4);
    run_op(32'd2, "b2b_2");
    check("b2b_2_const", 32'(y), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b2b_hold_vld", 32'(y_vld), 32'd0);
      check("b2b_hold_y", 32'(y), 32'd1);
    end

    // Reset mid-operation: aborts, clears y, no strobe.
    x_vld = 1'b1;
    x     = 32'd400;
    tick();
    x_vld = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      check("abort_vld", 32'(y_vld), 32'd0);
      check("abort_y", 32'(y), 32'd0);
      check("abort_rdy", 32'(x_rdy), 32'd1);
      tick();
    end
    run_op(32'd400, "after_abort");
    check("after_abort_const", 32'(y), 32'd20);
    tick();

    // Random sweep, each operand issued in the previous result's DONE cycle.
    for (int n = 0; n < N_RAND; n++) begin
      logic [31:0] v;
      int unsigned r;
      case ($urandom_range(3))
        0: v = $urandom;
        1: begin r = $urandom_range(65535); v = r * r; end
        2: begin r = $urandom_range(65535, 1); v = r * r - 1; end
        default: v = $urandom_range(1000);
      endcase
      run_op(v, "rand");
    end
    tick();
    check("rand_end_vld", 32'(y_vld), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
